// File: rtl/pc_redirect_ctrl.sv
// Next-PC redirect sequencer: boot, branch/jump resolution against the ALU compare,
// and trap redirects, presented to IF over a valid/ready handshake.
module pc_redirect_ctrl #(
  parameter logic [31:0] BOOT_ADDR   = 32'h0000_0080,
  parameter int unsigned CMP_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        br_valid_i,
  output logic        br_ready_o,
  input  logic [31:0] br_operand_a_i,
  input  logic [31:0] br_operand_b_i,
  input  logic        br_cond_i,
  input  logic        cmp_valid_i,
  input  logic        cmp_result_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_addr_i,
  output logic        trap_ack_o,
  output logic        redir_valid_o,
  input  logic        redir_ready_i,
  output logic [31:0] redir_pc_o,
  output logic        redir_taken_o,
  output logic        busy_o,
  output logic        cmp_timeout_o
);

  localparam int unsigned CW = $clog2(CMP_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_BOOT,
    S_IDLE,
    S_WAIT_CMP,
    S_REDIRECT
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          taken_q, taken_d;
  logic          ack_q, ack_d;
  logic          tmo_q, tmo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_BOOT;
      pc_q    <= BOOT_ADDR;
      taken_q <= 1'b0;
      ack_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    taken_d    = taken_q;
    ack_d      = 1'b0;
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    br_ready_o = (state_q == S_IDLE) && !trap_req_i;

    unique case (state_q)
      S_BOOT: begin
        state_d = S_REDIRECT;
        pc_d    = BOOT_ADDR;
        taken_d = 1'b1;
      end
      S_IDLE: begin
        // Trap has strict priority; br_ready_o is already low while it is pending.
        if (trap_req_i) begin
          state_d = S_REDIRECT;
          pc_d    = trap_addr_i & ~32'h3;
          taken_d = 1'b1;
          ack_d   = 1'b1;
        end else if (br_valid_i) begin
          if (!br_cond_i) begin
            state_d = S_REDIRECT;
            pc_d    = br_operand_a_i + br_operand_b_i;
            taken_d = 1'b1;
          end else if (cmp_valid_i) begin
            state_d = S_REDIRECT;
            pc_d    = cmp_result_i ? (br_operand_a_i + br_operand_b_i)
                                   : (br_operand_a_i + 32'd4);
            taken_d = cmp_result_i;
          end else begin
            state_d = S_WAIT_CMP;
            a_d     = br_operand_a_i;
            b_d     = br_operand_b_i;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT_CMP: begin
        cnt_d = cnt_q + CW'(1);
        if (trap_req_i) begin
          state_d = S_REDIRECT;
          pc_d    = trap_addr_i & ~32'h3;
          taken_d = 1'b1;
          ack_d   = 1'b1;
        end else if (cmp_valid_i) begin
          state_d = S_REDIRECT;
          pc_d    = cmp_result_i ? (a_q + b_q) : (a_q + 32'd4);
          taken_d = cmp_result_i;
        end else if (cnt_q == CW'(CMP_TIMEOUT - 1)) begin
          state_d = S_REDIRECT;
          pc_d    = a_q + 32'd4;
          taken_d = 1'b0;
          tmo_d   = 1'b1;
        end
      end
      S_REDIRECT: begin
        if (redir_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign redir_valid_o = (state_q == S_REDIRECT);
  assign redir_pc_o    = pc_q;
  assign redir_taken_o = taken_q;
  assign trap_ack_o    = ack_q;
  assign busy_o        = (state_q != S_IDLE);
  assign cmp_timeout_o = tmo_q;

endmodule
